// File: rtl/pmu_pkg.sv
// pmu_pkg: shared state encodings, register offsets and reset values for the PMU sequencer
package pmu_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_ISO    = 3'd1,
    ST_CKOFF  = 3'd2,
    ST_PWROFF = 3'd3,
    ST_SLEEP  = 3'd4,
    ST_PWRON  = 3'd5,
    ST_CKON   = 3'd6,
    ST_ISOOFF = 3'd7
  } pmu_state_e;

  typedef struct packed {
    logic iso_en;
    logic clk_off;
    logic pwr_off;
    logic core_rst_n;
    logic sleep_st;
  } pmu_out_t;

  localparam logic [5:0] A_CTRL      = 6'h00;
  localparam logic [5:0] A_WAKE_EN   = 6'h01;
  localparam logic [5:0] A_STATUS    = 6'h02;
  localparam logic [5:0] A_SLEEP_TMR = 6'h03;
  localparam logic [5:0] A_STEP_DLY  = 6'h04;

  localparam logic [3:0]  WAKE_EN_RST   = 4'h0;
  localparam logic [15:0] SLEEP_TMR_RST = 16'h0000;
  localparam logic [7:0]  STEP_DLY_RST  = 8'h04;

  localparam pmu_out_t OUT_RST = '{iso_en: 1'b0, clk_off: 1'b0, pwr_off: 1'b0, core_rst_n: 1'b1, sleep_st: 1'b0};

  // States that sit on the step counter for STEP_DLY+1 cycles
  function automatic logic is_step(input pmu_state_e s);
    return s != ST_RUN && s != ST_SLEEP;
  endfunction

endpackage

// File: rtl/pmu_seq_regs.sv
// pmu_seq_regs: four-phase APB-bridge handshake and PMU register file
//   pclk/presetn          clock, async active-low reset
//   pmu_pvalid/pwrite/paddr/pwdata  request from bridge (pvalid asynchronous)
//   pmu_ack/pmu_prdata    registered acknowledge and read data
//   state/cause           FSM state and sticky wake cause for STATUS
//   sleep_req             one-cycle SLEEP_REQ pulse to the FSM
//   cause_clr             write-1-to-clear mask for the cause bits
//   wake_en/sleep_tmr/step_dly  configuration registers
module pmu_seq_regs
  import pmu_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              pmu_pvalid,
  input  logic              pmu_pwrite,
  input  logic [5:0]        pmu_paddr,
  input  logic [31:0]       pmu_pwdata,
  output logic              pmu_ack,
  output logic [31:0]       pmu_prdata,
  input  pmu_state_e        state,
  input  logic [4:0]        cause,
  output logic              sleep_req,
  output logic [4:0]        cause_clr,
  output logic [3:0]        wake_en,
  output logic [15:0]       sleep_tmr,
  output logic [STEP_W-1:0] step_dly
);

  logic [1:0]  sync;
  logic        req_s;
  logic        wr;
  logic        rd;
  logic [31:0] rdata;
  logic        unused_wdata;

  assign req_s        = sync[1];
  assign wr           = req_s & ~pmu_ack & pmu_pwrite;
  assign rd           = req_s & ~pmu_ack & ~pmu_pwrite;
  assign sleep_req    = wr && pmu_paddr == A_CTRL && pmu_pwdata[0];
  assign cause_clr    = (wr && pmu_paddr == A_STATUS) ? pmu_pwdata[8:4] : 5'd0;
  assign unused_wdata = ^pmu_pwdata;

  always_comb begin
    rdata = pmu_paddr == A_WAKE_EN   ? {28'd0, wake_en} :
            pmu_paddr == A_STATUS    ? {23'd0, cause, 1'b0, state} :
            pmu_paddr == A_SLEEP_TMR ? {16'd0, sleep_tmr} :
            pmu_paddr == A_STEP_DLY  ? 32'(step_dly) : 32'd0;
  end

  // ack simply follows req_s: it rises with the access and falls once req_s drops
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync       <= 2'b00;
      pmu_ack    <= 1'b0;
      pmu_prdata <= 32'd0;
    end else begin
      sync    <= {sync[0], pmu_pvalid};
      pmu_ack <= req_s;
      if (rd) pmu_prdata <= rdata;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wake_en   <= WAKE_EN_RST;
      sleep_tmr <= SLEEP_TMR_RST;
      step_dly  <= STEP_W'(STEP_DLY_RST);
    end else if (wr) begin
      if (pmu_paddr == A_WAKE_EN)   wake_en   <= pmu_pwdata[3:0];
      if (pmu_paddr == A_SLEEP_TMR) sleep_tmr <= pmu_pwdata[15:0];
      if (pmu_paddr == A_STEP_DLY)  step_dly  <= pmu_pwdata[STEP_W-1:0];
    end
  end

endmodule

// File: rtl/pmu_seq_ctrl.sv
// pmu_seq_ctrl: power-down/wake sequencer FSM with step counter and sleep timer
//   pclk/presetn          clock, async active-low reset
//   pmu_*                 APB-bridge four-phase request/ack interface
//   wake_src              level wake sources (already synchronous to pclk)
//   iso_en/clk_off/pwr_off/core_rst_n  registered power controls
//   sleep_st              high only in SLEEP
module pmu_seq_ctrl
  import pmu_pkg::*;
#(
  parameter int D      = 0,
  parameter int STEP_W = 8
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        pmu_pvalid,
  input  logic        pmu_pwrite,
  input  logic [5:0]  pmu_paddr,
  input  logic [31:0] pmu_pwdata,
  output logic        pmu_ack,
  output logic [31:0] pmu_prdata,
  input  logic [3:0]  wake_src,
  output logic        iso_en,
  output logic        clk_off,
  output logic        pwr_off,
  output logic        core_rst_n,
  output logic        sleep_st
);

  if (D < 0) begin : g_bad_d
    $error("D must be non-negative");
  end

  pmu_state_e        state;
  pmu_state_e        nxt;
  logic              sleep_req;
  logic [4:0]        cause;
  logic [4:0]        cause_clr;
  logic [3:0]        wake_en;
  logic [15:0]       sleep_tmr;
  logic [STEP_W-1:0] step_dly;
  logic [STEP_W-1:0] cnt;
  logic [15:0]       tmr;
  logic              pend;
  logic [3:0]        pend_src;
  logic [3:0]        wake_hit;
  logic              tmr_exp;
  logic              sleep_exit;
  pmu_out_t          out_d;
  pmu_out_t          out_q;

  pmu_seq_regs #(.STEP_W(STEP_W)) u_regs (
    .pclk       (pclk),
    .presetn    (presetn),
    .pmu_pvalid (pmu_pvalid),
    .pmu_pwrite (pmu_pwrite),
    .pmu_paddr  (pmu_paddr),
    .pmu_pwdata (pmu_pwdata),
    .pmu_ack    (pmu_ack),
    .pmu_prdata (pmu_prdata),
    .state      (state),
    .cause      (cause),
    .sleep_req  (sleep_req),
    .cause_clr  (cause_clr),
    .wake_en    (wake_en),
    .sleep_tmr  (sleep_tmr),
    .step_dly   (step_dly)
  );

  // Timer holds 0 when disabled, so only a loaded non-zero value can expire
  assign wake_hit   = wake_src & wake_en;
  assign tmr_exp    = state == ST_SLEEP && tmr == 16'd1;
  assign sleep_exit = state == ST_SLEEP && nxt == ST_PWRON;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_RUN;
    else          state <= nxt;
  end

  // Step states are consecutive encodings, so +1 walks the sequence and wraps ISOOFF to RUN
  always_comb begin
    nxt = state == ST_RUN   ? (sleep_req ? ST_ISO : ST_RUN) :
          state == ST_SLEEP ? ((|wake_hit || tmr_exp || pend) ? ST_PWRON : ST_SLEEP) :
          cnt == '0         ? pmu_state_e'(state + 3'd1) : state;
  end

  // Outputs decoded from the next state so the registered levels line up with state
  always_comb begin
    out_d.iso_en     = nxt != ST_RUN && nxt != ST_ISOOFF;
    out_d.clk_off    = nxt >= ST_CKOFF && nxt <= ST_PWRON;
    out_d.pwr_off    = nxt == ST_PWROFF || nxt == ST_SLEEP;
    out_d.core_rst_n = !(nxt >= ST_PWROFF && nxt <= ST_PWRON);
    out_d.sleep_st   = nxt == ST_SLEEP;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) out_q <= OUT_RST;
    else          out_q <= out_d;
  end

  assign iso_en     = out_q.iso_en;
  assign clk_off    = out_q.clk_off;
  assign pwr_off    = out_q.pwr_off;
  assign core_rst_n = out_q.core_rst_n;
  assign sleep_st   = out_q.sleep_st;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
      tmr <= 16'd0;
    end else begin
      if (nxt != state && is_step(nxt)) cnt <= step_dly;
      else if (cnt != '0)               cnt <= cnt - STEP_W'(1);
      if (nxt == ST_SLEEP && state != ST_SLEEP)  tmr <= sleep_tmr;
      else if (state == ST_SLEEP && tmr != 16'd0) tmr <= tmr - 16'd1;
    end
  end

  // Wakes seen on the way down are held until SLEEP is reached, then replayed as cause
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pend     <= 1'b0;
      pend_src <= 4'd0;
      cause    <= 5'd0;
    end else begin
      if (sleep_exit) begin
        pend     <= 1'b0;
        pend_src <= 4'd0;
      end else if ((state == ST_ISO || state == ST_CKOFF || state == ST_PWROFF) && |wake_hit) begin
        pend     <= 1'b1;
        pend_src <= pend_src | wake_hit;
      end
      cause <= (cause & ~cause_clr) | (sleep_exit ? {wake_hit | pend_src, tmr_exp} : 5'd0);
    end
  end

endmodule

// File: tb/tb_pmu_seq_ctrl.sv
// tb_pmu_seq_ctrl: directed self-checking bench for the PMU sequencer
module tb_pmu_seq_ctrl;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        pmu_pvalid = 1'b0;
  logic        pmu_pwrite = 1'b0;
  logic [5:0]  pmu_paddr = 6'd0;
  logic [31:0] pmu_pwdata = 32'd0;
  logic        pmu_ack;
  logic [31:0] pmu_prdata;
  logic [3:0]  wake_src = 4'd0;
  logic        iso_en, clk_off, pwr_off, core_rst_n, sleep_st;

  int checks = 0;
  int errors = 0;
  int cyc_in[8];
  int out_bad;
  bit seq_ok;

  logic [7:0] tbl_iso  = 8'b0111_1110;
  logic [7:0] tbl_clk  = 8'b0011_1100;
  logic [7:0] tbl_pwr  = 8'b0001_1000;
  logic [7:0] tbl_rstn = 8'b1100_0111;
  logic [7:0] tbl_slp  = 8'b0001_0000;

  pmu_seq_ctrl dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .pmu_pvalid (pmu_pvalid),
    .pmu_pwrite (pmu_pwrite),
    .pmu_paddr  (pmu_paddr),
    .pmu_pwdata (pmu_pwdata),
    .pmu_ack    (pmu_ack),
    .pmu_prdata (pmu_prdata),
    .wake_src   (wake_src),
    .iso_en     (iso_en),
    .clk_off    (clk_off),
    .pwr_off    (pwr_off),
    .core_rst_n (core_rst_n),
    .sleep_st   (sleep_st)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [5:0] a, input logic [31:0] d,
                          output logic [31:0] q, output int rise, output int fall, output bit stable);
    rise = 0;
    fall = 0;
    stable = 1'b1;
    pmu_pwrite = wr;
    pmu_paddr = a;
    pmu_pwdata = d;
    pmu_pvalid = 1'b1;
    while (!pmu_ack && rise < 20) begin
      tick();
      rise++;
    end
    if (!pmu_ack) begin
      errors++;
      $display("FAIL ack_rise_timeout addr=%0h ack=%b required 1", a, pmu_ack);
    end
    q = pmu_prdata;
    pmu_pvalid = 1'b0;
    while (pmu_ack && fall < 20) begin
      if (pmu_prdata !== q) stable = 1'b0;
      tick();
      fall++;
    end
    if (pmu_ack) begin
      errors++;
      $display("FAIL ack_fall_timeout addr=%0h ack=%b required 0", a, pmu_ack);
    end
  endtask

  task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] q;
    int r, f;
    bit s;
    apb_xfer(1'b1, a, d, q, r, f, s);
  endtask

  task automatic apb_read(input logic [5:0] a, output logic [31:0] q);
    int r, f;
    bit s;
    apb_xfer(1'b0, a, 32'd0, q, r, f, s);
  endtask

  // Records cycles spent per state from leaving RUN until back in RUN, checking output levels each cycle
  task automatic run_seq(input int wake_state, input int budget);
    int n = 0;
    bit pulsed = 0;
    for (int i = 0; i < 8; i++) cyc_in[i] = 0;
    out_bad = 0;
    while (int'(dut.state) == 0 && n < budget) begin
      tick();
      n++;
    end
    while (int'(dut.state) != 0 && n < budget) begin
      int s;
      s = int'(dut.state);
      cyc_in[s]++;
      if ({iso_en, clk_off, pwr_off, core_rst_n, sleep_st} !==
          {tbl_iso[s], tbl_clk[s], tbl_pwr[s], tbl_rstn[s], tbl_slp[s]}) out_bad++;
      if (wake_src != 4'd0) wake_src = 4'd0;
      else if (!pulsed && s == wake_state) begin
        wake_src = 4'h1;
        pulsed = 1;
      end
      tick();
      n++;
    end
    wake_src = 4'd0;
    seq_ok = n < budget;
  endtask

  task automatic check_seq(input string name, input int sleep_cycles);
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL %s_timeout sequence did not return to RUN", name);
    end
    for (int s = 1; s < 8; s++) begin
      int want;
      want = (s == 4) ? sleep_cycles : 3;
      checks++;
      if (cyc_in[s] !== want) begin
        errors++;
        $display("FAIL %s_cycles state=%0d got %0d required %0d", name, s, cyc_in[s], want);
      end
    end
    checks++;
    if (out_bad !== 0) begin
      errors++;
      $display("FAIL %s_outputs %0d cycles with wrong output levels, required 0", name, out_bad);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({pmu_ack, iso_en, clk_off, pwr_off, core_rst_n, sleep_st} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_outputs got %b required 000010", {pmu_ack, iso_en, clk_off, pwr_off, core_rst_n, sleep_st});
    end
    checks++;
    if (pmu_prdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_prdata got %h required 0", pmu_prdata);
    end
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_wake_en_rw();
    logic [31:0] q;
    int r, f;
    bit s;
    apb_xfer(1'b1, 6'h01, 32'h3, q, r, f, s);
    checks++;
    if (r < 2 || r > 3) begin
      errors++;
      $display("FAIL ack_rise_latency got %0d required 2..3", r);
    end
    checks++;
    if (f < 2 || f > 3) begin
      errors++;
      $display("FAIL ack_fall_latency got %0d required 2..3", f);
    end
    apb_read(6'h01, q);
    checks++;
    if (q !== 32'h3) begin
      errors++;
      $display("FAIL wake_en_readback got %h required 3", q);
    end
  endtask

  task automatic test_read_status();
    logic [31:0] q;
    int r, f;
    bit s;
    apb_xfer(1'b0, 6'h04, 32'd0, q, r, f, s);
    checks++;
    if (q !== 32'h4) begin
      errors++;
      $display("FAIL step_dly_reset got %h required 4", q);
    end
    apb_xfer(1'b0, 6'h02, 32'd0, q, r, f, s);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL status_run got %h required 0", q);
    end
    checks++;
    if (!s) begin
      errors++;
      $display("FAIL prdata_stable got unstable required stable");
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] q;
    apb_write(6'h3F, 32'hFFFF_FFFF);
    apb_read(6'h3F, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read got %h required 0", q);
    end
    apb_read(6'h00, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_read got %h required 0", q);
    end
  endtask

  task automatic test_sleep_wake();
    logic [31:0] q;
    apb_write(6'h04, 32'd2);
    fork
      apb_write(6'h00, 32'h1);
      run_seq(4, 400);
    join
    check_seq("src_wake", 1);
    apb_read(6'h02, q);
    checks++;
    if (q !== 32'h20) begin
      errors++;
      $display("FAIL src_wake_cause got %h required 20", q);
    end
    apb_write(6'h02, 32'h1F0);
    apb_read(6'h02, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL cause_clear got %h required 0", q);
    end
  endtask

  task automatic test_timer_wake();
    logic [31:0] q;
    apb_write(6'h01, 32'h0);
    apb_write(6'h03, 32'd10);
    fork
      apb_write(6'h00, 32'h1);
      run_seq(-1, 400);
    join
    check_seq("tmr_wake", 10);
    apb_read(6'h02, q);
    checks++;
    if (q !== 32'h10) begin
      errors++;
      $display("FAIL tmr_cause got %h required 10", q);
    end
    apb_write(6'h02, 32'h10);
    apb_read(6'h02, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL tmr_cause_clear got %h required 0", q);
    end
  endtask

  task automatic test_pending_wake();
    apb_write(6'h01, 32'h1);
    apb_write(6'h03, 32'd0);
    fork
      apb_write(6'h00, 32'h1);
      run_seq(2, 400);
    join
    check_seq("pend_wake", 1);
    apb_write(6'h02, 32'h1F0);
  endtask

  task automatic test_reset_in_pwroff();
    logic [31:0] q;
    int n = 0;
    apb_write(6'h04, 32'd6);
    apb_write(6'h01, 32'h5);
    apb_write(6'h00, 32'h1);
    while (int'(dut.state) != 3 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (int'(dut.state) != 3) begin
      errors++;
      $display("FAIL reach_pwroff got state %0d required 3", int'(dut.state));
    end
    pmu_pwrite = 1'b0;
    pmu_paddr = 6'h01;
    pmu_pvalid = 1'b1;
    repeat (4) tick();
    checks++;
    if ({pmu_ack, pmu_prdata, pwr_off} !== {1'b1, 32'h5, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset got ack=%b prdata=%h pwr_off=%b required 1/5/1", pmu_ack, pmu_prdata, pwr_off);
    end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({pmu_ack, iso_en, clk_off, pwr_off, core_rst_n, sleep_st} !== 6'b000010 || pmu_prdata !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got %b prdata=%h required 000010 prdata=0",
               {pmu_ack, iso_en, clk_off, pwr_off, core_rst_n, sleep_st}, pmu_prdata);
    end
    checks++;
    if (int'(dut.state) != 0) begin
      errors++;
      $display("FAIL async_reset_state got %0d required 0", int'(dut.state));
    end
    pmu_pvalid = 1'b0;
    repeat (2) tick();
    presetn = 1'b1;
    tick();
    apb_read(6'h04, q);
    checks++;
    if (q !== 32'h4) begin
      errors++;
      $display("FAIL post_reset_step_dly got %h required 4", q);
    end
    apb_read(6'h01, q);
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_wake_en got %h required 0", q);
    end
  endtask

  initial begin
    test_reset();
    test_wake_en_rw();
    test_read_status();
    test_unmapped();
    test_sleep_wake();
    test_timer_wake();
    test_pending_wake();
    test_reset_in_pwroff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmu_seq_ctrl.md
PMU_SEQ_CTRL -- requirements
Module: pmu_seq_ctrl

Interface
REQ-001 SHALL have parameter D, default 0, giving the register-update delay for simulation only.
REQ-002 SHALL have parameter STEP_W, default 8, giving the width of the per-step delay counter.
REQ-003 pclk  in  1  PMU slow clock; the block's only clock.
REQ-004 presetn  in  1  reset, asynchronous assert, active-low.
REQ-005 pmu_pvalid  in  1  request level from the APB bridge; asynchronous to pclk.
REQ-006 pmu_pwrite  in  1  1 = write, 0 = read; quasi-static while pmu_pvalid is high.
REQ-007 pmu_paddr  in  6  word address [7:2]; quasi-static.
REQ-008 pmu_pwdata  in  32  write data; quasi-static.
REQ-009 pmu_ack  out  1  four-phase acknowledge, registered.
REQ-010 pmu_prdata  out  32  read data, registered; stable while pmu_ack is high.
REQ-011 wake_src  in  4  level wake sources, synchronised to pclk outside this block.
REQ-012 iso_en, clk_off, pwr_off, core_rst_n  out  1 each  isolation, clock gate, power switch and core reset controls.
REQ-013 sleep_st  out  1  high only in state SLEEP.

Function
REQ-014 SHALL synchronise pmu_pvalid through 2 flops to produce req_s.
REQ-015 Handshake: when req_s=1 and pmu_ack=0, SHALL perform the access and set pmu_ack=1 in the same edge.
REQ-016 Handshake: when req_s=0 and pmu_ack=1, SHALL clear pmu_ack; there are no other ack transitions.
REQ-017 A read SHALL load pmu_prdata in the same edge that ack rises; pmu_prdata SHALL otherwise hold.
REQ-018 Register map by paddr: 0x00 CTRL, 0x01 WAKE_EN, 0x02 STATUS, 0x03 SLEEP_TMR, 0x04 STEP_DLY.
REQ-019 CTRL: bit0 SLEEP_REQ, write-1 pulse, reads 0.
REQ-020 WAKE_EN: [3:0] RW, reset 0.
REQ-021 STATUS: [3:0] FSM state (RO); [8:4] sticky wake cause (bit4 = timer, bits8:5 = wake_src), cleared by writing 1 to the bit.
REQ-022 SLEEP_TMR: [15:0] RW, reset 0; 0 = timer disabled.
REQ-023 STEP_DLY: [STEP_W-1:0] RW, reset 8'h04.
REQ-024 Unmapped addresses SHALL read 0 and ignore writes.
REQ-025 FSM encodings: RUN=0, ISO=1, CKOFF=2, PWROFF=3, SLEEP=4, PWRON=5, CKON=6, ISOOFF=7.
REQ-026 SLEEP_REQ in RUN SHALL move the FSM to ISO; SLEEP_REQ in any other state SHALL be ignored.
REQ-027 Each of ISO, CKOFF, PWROFF, PWRON, CKON, ISOOFF SHALL load the step counter with STEP_DLY on entry and advance to the next state when the counter reaches 0, giving STEP_DLY+1 cycles per state.
REQ-028 Order: ISO -> CKOFF -> PWROFF -> SLEEP -> PWRON -> CKON -> ISOOFF -> RUN.
REQ-029 Output levels by state:
- iso_en = 1 in states ISO through CKON.
- clk_off = 1 in states CKOFF through PWRON.
- pwr_off = 1 in PWROFF and SLEEP.
- core_rst_n = 0 in PWROFF, SLEEP and PWRON.
- All outputs are registered.
REQ-030 Wake event = |(wake_src & WAKE_EN) or timer expiry.
- In SLEEP it SHALL move the FSM to PWRON and set the cause bits.
- During ISO, CKOFF or PWROFF it SHALL be latched as pending; the FSM SHALL complete entry and leave SLEEP after exactly 1 cycle.
REQ-031 Timer: loaded with SLEEP_TMR on SLEEP entry and decremented each cycle in SLEEP; expiry when it reaches 0, giving SLEEP_TMR cycles in SLEEP.
REQ-032 A register write and an FSM event in the same cycle SHALL both take effect. A STEP_DLY write SHALL apply from the next step load.

Reset
REQ-033 On presetn low SHALL asynchronously force the following, regardless of an in-flight handshake or sequence:
- FSM = RUN.
- pmu_ack = 0, pmu_prdata = 0.
- iso_en = clk_off = pwr_off = 0, core_rst_n = 1.
- Synchroniser, counters, pending flag and cause = 0.
- Registers to their reset values.

Structure
REQ-034 State encodings, register offsets and reset values SHALL live in shared package pmu_pkg.
REQ-035 The APB handshake and register file SHALL be sub-module pmu_seq_regs; the FSM, step counter and timer SHALL stay in pmu_seq_ctrl.

Verification
REQ-036 Write WAKE_EN=4'h3 with a full four-phase handshake -> ack rises 2-3 pclk after pvalid and falls 2-3 pclk after pvalid drops; readback 0x3.
REQ-037 Read STATUS in RUN -> pmu_prdata=0, stable while ack=1.
REQ-038 STEP_DLY=2, SLEEP_REQ, wake_src[0]=1 with WAKE_EN[0]=1 after SLEEP is reached -> 3 cycles each in ISO/CKOFF/PWROFF, wake via PWRON/CKON/ISOOFF, STATUS cause=5'b00010.
REQ-039 SLEEP_TMR=10, WAKE_EN=0, SLEEP_REQ -> exactly 10 cycles in SLEEP, cause bit4 set; write 1 to bit4 clears it.
REQ-040 wake_src pulse during CKOFF -> SLEEP lasts 1 cycle, then normal exit.
REQ-041 presetn asserted in PWROFF with pvalid high -> all outputs at reset values immediately; new handshake completes after release.
